alu_seq_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_seq_unit_if.sv | 27 ++
 rtl/alu_iter_mdu.sv | 82 ++++++++
 rtl/alu_seq_unit.sv | 115 +++++++++++
 tb/tb_alu_seq_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op-code values, FSM state
// encoding and the iterative-op classifier.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for ops that go through the multi-cycle multiply/divide path.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Operand/result handshake bundle between ID/EX operand muxing, the ALU and
// the EX/MEM register.
interface alu_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             op_illegal;
    logic             busy;

    modport master (
        output in_valid, SrcA, SrcB, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, op_illegal, busy
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, Zero, op_illegal, busy
    );
endinterface

// File: rtl/alu_iter_mdu.sv
// Iterative multiply/divide: shift-add multiplier and restoring divider, one
// bit per clock, exactly WIDTH steps. done pulses with the final result.
module alu_iter_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CNT_W = $clog2(WIDTH);

    // acc: product accumulator (MUL) or partial remainder (DIV/REM)
    // x:   shifted multiplicand (MUL) or dividend/quotient shifter (DIV/REM)
    // y:   shifted multiplier (MUL) or divisor (DIV/REM)
    logic             active_reg;
    logic [3:0]       op_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] x_next;
    logic [WIDTH-1:0] y_next;
    logic [WIDTH:0]   r_shift;
    logic             ge;

    always_comb begin
        r_shift  = {acc_reg, x_reg[WIDTH-1]};
        ge       = (r_shift >= {1'b0, y_reg});
        acc_next = acc_reg;
        x_next   = x_reg;
        y_next   = y_reg;
        if (op_reg == OP_MUL) begin
            acc_next = acc_reg + (y_reg[0] ? x_reg : '0);
            x_next   = x_reg << 1;
            y_next   = y_reg >> 1;
        end else begin
            // A zero divisor always "fits", which yields all-ones quotient and
            // leaves the dividend in the remainder without any special case.
            acc_next = ge ? WIDTH'(r_shift - {1'b0, y_reg}) : r_shift[WIDTH-1:0];
            x_next   = {x_reg[WIDTH-2:0], ge};
        end
    end

    assign done   = active_reg && (cnt_reg == CNT_W'(WIDTH - 1));
    assign result = (op_reg == OP_DIVU) ? x_next : acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg <= 1'b0;
            op_reg     <= OP_MUL;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
        end else if (start) begin
            active_reg <= 1'b1;
            op_reg     <= op;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            x_reg      <= a;
            y_reg      <= b;
        end else if (active_reg) begin
            acc_reg <= acc_next;
            x_reg   <= x_next;
            y_reg   <= y_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (done) begin
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU with valid/ready handshake and a registered result.
// Define ALU_SEQ_MDU_EN to build the iterative MUL/DIVU/REMU path.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_unit_if.slave bus
);
    state_t           state_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             illegal_reg;

    logic             accept;
    logic             op_iter;
    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;
    logic [SHAMT_W-1:0] shamt;

    assign bus.in_ready   = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = (state_reg == DONE);
    assign bus.busy       = (state_reg == ITER);
    assign bus.ALUResult  = result_reg;
    assign bus.Zero       = zero_reg;
    assign bus.op_illegal = illegal_reg;
    assign shamt          = bus.SrcB[SHAMT_W-1:0];

    // Single-cycle datapath; iterative codes are only legal with the MDU built.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (bus.ALUControl)
            OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
            OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
            OP_AND:  alu_res = bus.SrcA & bus.SrcB;
            OP_OR:   alu_res = bus.SrcA | bus.SrcB;
            OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            OP_SLL:  alu_res = bus.SrcA << shamt;
            OP_SRL:  alu_res = bus.SrcA >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.SrcA) >>> shamt);
`ifdef ALU_SEQ_MDU_EN
            OP_MUL, OP_DIVU, OP_REMU: alu_res = '0;
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MDU_EN
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_result;

    assign op_iter = is_iterative(bus.ALUControl);

    alu_iter_mdu #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && op_iter),
        .op     (bus.ALUControl),
        .a      (bus.SrcA),
        .b      (bus.SrcB),
        .done   (mdu_done),
        .result (mdu_result)
    );
`else
    assign op_iter = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (accept) begin
            // Covers both a fresh issue from IDLE and back-to-back issue from DONE.
            if (op_iter) begin
                state_reg <= ITER;
            end else begin
                state_reg   <= DONE;
                result_reg  <= alu_res;
                zero_reg    <= (alu_res == '0);
                illegal_reg <= alu_illegal;
            end
        end else begin
            case (state_reg)
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
`ifdef ALU_SEQ_MDU_EN
                ITER: begin
                    if (mdu_done) begin
                        state_reg   <= DONE;
                        result_reg  <= mdu_result;
                        zero_reg    <= (mdu_result == '0);
                        illegal_reg <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed spec cases, back-to-back
// throughput, backpressure, random ops and reset abort against a reference model.
module tb_alu_seq_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_seq_unit_if #(.WIDTH(W)) bus ();

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the op table: plain arithmetic.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ill, output int lat);
        res = '0;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0:  res = a + b;
            4'd1:  res = a - b;
            4'd2:  res = a & b;
            4'd3:  res = a | b;
            4'd4:  res = a ^ b;
            4'd5:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  res = (a < b) ? 32'd1 : 32'd0;
            4'd7:  res = a << b[4:0];
            4'd8:  res = a >> b[4:0];
            4'd9:  res = $unsigned($signed(a) >>> b[4:0]);
`ifdef ALU_SEQ_MDU_EN
            4'd10: begin res = a * b; lat = W + 1; end
            4'd11: begin res = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = W + 1; end
            4'd12: begin res = (b == 0) ? a : a % b; lat = W + 1; end
`endif
            default: ill = 1'b1;
        endcase
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
        check_eq({tag, "_out_valid"}, bus.out_valid, 0);
        check_eq({tag, "_result"}, bus.ALUResult, 0);
        check_eq({tag, "_zero"}, bus.Zero, 0);
        check_eq({tag, "_illegal"}, bus.op_illegal, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
    endtask

    // Issue one op with out_ready=1 and check latency, busy window and result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic        ill;
        int          lat, cyc, guard, busy_n, rdy_lo;
        ref_op(op, a, b, res, ill, lat);
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_in_ready"}, bus.in_ready, 1);
        bus.in_valid   = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.SrcA     = $urandom;
        bus.SrcB     = $urandom;
        cyc    = 1;
        busy_n = 0;
        rdy_lo = 0;
        while (!bus.out_valid && cyc < 200) begin
            if (bus.busy) busy_n++;
            if (!bus.in_ready) rdy_lo++;
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_latency"}, cyc, lat);
        check_eq({tag, "_result"}, bus.ALUResult, res);
        check_eq({tag, "_zero"}, bus.Zero, (res == 0));
        check_eq({tag, "_illegal"}, bus.op_illegal, ill);
        if (lat > 1) begin
            check_eq({tag, "_busy_cycles"}, busy_n, W);
            check_eq({tag, "_in_ready_low"}, rdy_lo, W);
        end
        $display("txn %-10s op=%0d a=%08h b=%08h res=%08h ill=%0d lat=%0d", tag, op, a, b,
                 bus.ALUResult, bus.op_illegal, cyc);
    endtask

    initial begin
        logic [31:0] res, prev_res, exp_or, exp_add;
        logic        ill;
        int          lat, ov_cnt;
        logic [3:0]  op;
        logic [31:0] a, b;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        bus.ALUControl = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        run_op("add", 4'd0, 32'd5, 32'd3);
        run_op("sub", 4'd1, 32'd5, 32'd5);
        run_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1);
        run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1);
        run_op("sra", 4'd9, 32'h8000_0000, 32'd4);
        run_op("sll35", 4'd7, 32'd1, 32'd35);
        run_op("xor", 4'd4, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
        run_op("srl", 4'd8, 32'h8000_0000, 32'd31);
        run_op("mul", 4'd10, 32'd7, 32'd6);
        run_op("divu", 4'd11, 32'd100, 32'd7);
        run_op("remu", 4'd12, 32'd100, 32'd7);
        run_op("divu0", 4'd11, 32'h1234_5678, 32'd0);
        run_op("remu0", 4'd12, 32'd9, 32'd0);
        run_op("illegal", 4'd15, 32'd3, 32'd4);
        run_op("op1010", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Back-to-back single-cycle ops: one result per clock.
        prev_res = '0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                check_eq("b2b_out_valid", bus.out_valid, 1);
                check_eq("b2b_result", bus.ALUResult, prev_res);
            end
            check_eq("b2b_in_ready", bus.in_ready, 1);
            op = 4'($urandom_range(0, 9));
            a  = $urandom;
            b  = $urandom;
            ref_op(op, a, b, res, ill, lat);
            bus.in_valid = 1'b1; bus.ALUControl = op; bus.SrcA = a; bus.SrcB = b;
            prev_res = res;
            $display("txn b2b%0d      op=%0d a=%08h b=%08h exp=%08h", i, op, a, b, res);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_eq("b2b_last_valid", bus.out_valid, 1);
        check_eq("b2b_last_result", bus.ALUResult, prev_res);

        // Backpressure: hold the OR result, then release with a new op waiting.
        @(negedge clk);
        a = $urandom; b = $urandom;
        ref_op(4'd3, a, b, exp_or, ill, lat);
        bus.in_valid = 1'b1; bus.ALUControl = 4'd3; bus.SrcA = a; bus.SrcB = b;
        bus.out_ready = 1'b0;
        @(negedge clk);
        a = $urandom; b = $urandom;
        ref_op(4'd0, a, b, exp_add, ill, lat);
        bus.ALUControl = 4'd0; bus.SrcA = a; bus.SrcB = b;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_out_valid", bus.out_valid, 1);
            check_eq("bp_hold_result", bus.ALUResult, exp_or);
            check_eq("bp_hold_zero", bus.Zero, (exp_or == 0));
            check_eq("bp_in_ready", bus.in_ready, 0);
            if (k < 4) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_eq("bp_new_valid", bus.out_valid, 1);
        check_eq("bp_new_result", bus.ALUResult, exp_add);
        $display("txn backpress or=%08h add=%08h", exp_or, exp_add);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 40);
                default: b = $urandom;
            endcase
            run_op("rand", op, a, b);
        end

        // Abort a division mid-flight with reset; nothing stale may emerge.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.ALUControl = 4'd11; bus.SrcA = 32'd1000; bus.SrcB = 32'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        ov_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) ov_cnt++;
        end
        check_eq("midreset_no_stale", ov_cnt, 0);
        $display("txn divu_abort  stale_valid_cycles=%0d", ov_cnt);
        run_op("post_add", 4'd0, 32'd1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
